// File: rtl/pipeline_pkg.sv
// Shared pipeline constants, MEM-stage FSM encoding and the MEM/WB bundle.
package pipeline_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;

   // MEM-stage access FSM: IDLE accepts work, WAIT holds one outstanding access.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   // Everything the writeback stage needs from MEM.
   typedef struct packed {
      logic                  valid;
      logic [XLEN-1:0]       read_data;
      logic [XLEN-1:0]       alu_result;
      logic [REG_ADDR_W-1:0] write_reg;
      logic                  memtoreg;
      logic                  regwrite;
   } mem_wb_t;

   // Doubleword accesses must have the low three address bits clear.
   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return (addr[2:0] != 3'b000);
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Handshaked data-memory port: the MEM stage is master, the memory is slave.
interface mem_access_stage_if;
   import pipeline_pkg::*;

   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] rdata;
   logic            ready;

   modport master (output req, output we, output addr, output wdata,
                   input rdata, input ready);
   modport slave  (input req, input we, input addr, input wdata,
                   output rdata, output ready);
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears the whole bundle.
module mem_wb_reg
   import pipeline_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    load_bubble,
   input  mem_wb_t d,
   output mem_wb_t q
);

   // Capture the retiring instruction, or a bubble when nothing retires.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (load_bubble) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory handshake, stalls upstream while an
// access is outstanding, resolves branches and feeds the MEM/WB register.
module mem_access_stage
   import pipeline_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [XLEN-1:0]       pc_in,
   input  logic                  zero_in,
   input  logic [XLEN-1:0]       alu_result_in,
   input  logic [XLEN-1:0]       store_data_in,
   input  logic [REG_ADDR_W-1:0] write_reg_in,
   input  logic                  branch_in,
   input  logic                  memwrite_in,
   input  logic                  memread_in,
   input  logic                  memtoreg_in,
   input  logic                  regwrite_in,
   output logic                  stall_out,
   output logic                  pcsrc_out,
   output logic [XLEN-1:0]       branch_target_out,
   mem_access_stage_if.master    dmem,
   output logic                  misalign_err,
   output logic                  wb_valid,
   output logic [XLEN-1:0]       wb_read_data,
   output logic [XLEN-1:0]       wb_alu_result,
   output logic [REG_ADDR_W-1:0] wb_write_reg,
   output logic                  wb_memtoreg,
   output logic                  wb_regwrite
);

   logic [0:0]            state_r;
   logic [0:0]            state_nxt_s;
   logic [XLEN-1:0]       hold_addr_r;
   logic [XLEN-1:0]       hold_wdata_r;
   logic                  hold_we_r;
   logic [REG_ADDR_W-1:0] hold_wreg_r;
   logic                  hold_memtoreg_r;
   logic                  hold_regwrite_r;
   logic                  mem_op_s;
   logic                  misal_s;
   logic                  accept_s;
   logic                  stall_s;
   logic                  misalign_s;
   logic                  bubble_s;
   mem_wb_t               wb_d_s;
   mem_wb_t               wb_q_s;

   assign mem_op_s = in_valid & (memread_in | memwrite_in);
   assign misal_s  = is_misaligned(alu_result_in);
   assign accept_s = (state_r == ST_IDLE) & mem_op_s & ~misal_s;

   // Next-state, stall and MEM/WB input selection.
   always_comb begin
      state_nxt_s = state_r;
      stall_s     = 1'b0;
      misalign_s  = 1'b0;
      bubble_s    = 1'b1;
      wb_d_s      = '0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_WAIT;
               stall_s     = 1'b1;
            end else if (mem_op_s) begin
               // Misaligned: retire without touching memory or the register file.
               misalign_s        = 1'b1;
               bubble_s          = 1'b0;
               wb_d_s.valid      = 1'b1;
               wb_d_s.alu_result = alu_result_in;
               wb_d_s.write_reg  = write_reg_in;
               wb_d_s.memtoreg   = memtoreg_in;
               wb_d_s.regwrite   = 1'b0;
            end else if (in_valid) begin
               bubble_s          = 1'b0;
               wb_d_s.valid      = 1'b1;
               wb_d_s.alu_result = alu_result_in;
               wb_d_s.write_reg  = write_reg_in;
               wb_d_s.memtoreg   = memtoreg_in;
               wb_d_s.regwrite   = regwrite_in;
            end else begin
               bubble_s = 1'b1;
            end
         end
         ST_WAIT: begin
            stall_s = ~dmem.ready;
            if (dmem.ready) begin
               state_nxt_s       = ST_IDLE;
               bubble_s          = 1'b0;
               wb_d_s.valid      = 1'b1;
               wb_d_s.read_data  = hold_we_r ? {XLEN{1'b0}} : dmem.rdata;
               wb_d_s.alu_result = hold_addr_r;
               wb_d_s.write_reg  = hold_wreg_r;
               wb_d_s.memtoreg   = hold_memtoreg_r;
               wb_d_s.regwrite   = hold_regwrite_r;
            end else begin
               bubble_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            bubble_s    = 1'b1;
         end
      endcase
   end

   // FSM state register; reset abandons any outstanding access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Holding registers keep the request stable until the memory is ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_addr_r     <= {XLEN{1'b0}};
         hold_wdata_r    <= {XLEN{1'b0}};
         hold_we_r       <= 1'b0;
         hold_wreg_r     <= {REG_ADDR_W{1'b0}};
         hold_memtoreg_r <= 1'b0;
         hold_regwrite_r <= 1'b0;
      end else if (accept_s) begin
         hold_addr_r     <= alu_result_in;
         hold_wdata_r    <= store_data_in;
         hold_we_r       <= memwrite_in;
         hold_wreg_r     <= write_reg_in;
         hold_memtoreg_r <= memtoreg_in;
         // A store never writes the register file, even if memread is also set.
         hold_regwrite_r <= regwrite_in & ~memwrite_in;
      end else begin
         hold_addr_r     <= hold_addr_r;
         hold_wdata_r    <= hold_wdata_r;
         hold_we_r       <= hold_we_r;
         hold_wreg_r     <= hold_wreg_r;
         hold_memtoreg_r <= hold_memtoreg_r;
         hold_regwrite_r <= hold_regwrite_r;
      end
   end

   mem_wb_reg u_mem_wb_reg (
      .clk         (clk),
      .rst         (rst),
      .load_bubble (bubble_s),
      .d           (wb_d_s),
      .q           (wb_q_s)
   );

   assign stall_out         = stall_s;
   assign misalign_err      = misalign_s;
   assign pcsrc_out         = in_valid & branch_in & zero_in & (state_r == ST_IDLE);
   assign branch_target_out = pc_in;

   assign dmem.req   = (state_r == ST_WAIT);
   assign dmem.we    = hold_we_r;
   assign dmem.addr  = hold_addr_r;
   assign dmem.wdata = hold_wdata_r;

   assign wb_valid      = wb_q_s.valid;
   assign wb_read_data  = wb_q_s.read_data;
   assign wb_alu_result = wb_q_s.alu_result;
   assign wb_write_reg  = wb_q_s.write_reg;
   assign wb_memtoreg   = wb_q_s.memtoreg;
   assign wb_regwrite   = wb_q_s.regwrite;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a random
// instruction stream against an instruction-level reference model.
module tb_mem_access_stage;
   import pipeline_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic [XLEN-1:0]       pc_in;
   logic                  zero_in;
   logic [XLEN-1:0]       alu_result_in;
   logic [XLEN-1:0]       store_data_in;
   logic [REG_ADDR_W-1:0] write_reg_in;
   logic                  branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in;
   logic                  stall_out, pcsrc_out, misalign_err;
   logic [XLEN-1:0]       branch_target_out;
   logic                  wb_valid, wb_memtoreg, wb_regwrite;
   logic [XLEN-1:0]       wb_read_data, wb_alu_result;
   logic [REG_ADDR_W-1:0] wb_write_reg;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic                  valid;
      logic [XLEN-1:0]       rd;
      logic [XLEN-1:0]       alu;
      logic [REG_ADDR_W-1:0] wreg;
      logic                  mtr;
      logic                  rw;
   } exp_wb_t;

   logic [XLEN-1:0] model_mem [logic [XLEN-1:0]];
   logic [XLEN-1:0] resp_mem  [logic [XLEN-1:0]];

   mem_access_stage_if dmem_bus ();

   mem_access_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in), .zero_in(zero_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .write_reg_in(write_reg_in), .branch_in(branch_in), .memwrite_in(memwrite_in),
      .memread_in(memread_in), .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
      .stall_out(stall_out), .pcsrc_out(pcsrc_out), .branch_target_out(branch_target_out),
      .dmem(dmem_bus), .misalign_err(misalign_err), .wb_valid(wb_valid),
      .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
      .wb_write_reg(wb_write_reg), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite)
   );

   always #5 clk = ~clk;

   // Initial memory image seen by both the reference model and the responder.
   function automatic logic [XLEN-1:0] init_val(input logic [XLEN-1:0] a);
      return a ^ 64'h5A5A_C3C3_0F0F_9696 ^ {a[31:0], a[63:32]};
   endfunction

   task automatic set_instr(input logic v, input logic [XLEN-1:0] pc, input logic z,
                            input logic [XLEN-1:0] alu, input logic [XLEN-1:0] sd,
                            input logic [REG_ADDR_W-1:0] wr, input logic br,
                            input logic mw, input logic mr, input logic mtr,
                            input logic rw);
      in_valid = v; pc_in = pc; zero_in = z; alu_result_in = alu; store_data_in = sd;
      write_reg_in = wr; branch_in = br; memwrite_in = mw; memread_in = mr;
      memtoreg_in = mtr; regwrite_in = rw;
   endtask

   task automatic clear_inputs();
      set_instr(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      dmem_bus.ready = 1'b0;
      dmem_bus.rdata = 64'h0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      #12;
      n_cmp++;
      if ({wb_valid, wb_regwrite, wb_memtoreg, wb_write_reg} !== 8'h00) begin
         n_err++; $display("FAIL reset_wb_ctrl: got %h expected 00", {wb_valid, wb_regwrite, wb_memtoreg, wb_write_reg});
      end
      n_cmp++;
      if ({wb_read_data, wb_alu_result} !== 128'h0) begin
         n_err++; $display("FAIL reset_wb_data: got %h expected 0", {wb_read_data, wb_alu_result});
      end
      n_cmp++;
      if ({dmem_bus.req, stall_out, misalign_err, pcsrc_out} !== 4'b0000) begin
         n_err++; $display("FAIL reset_outputs: got %b expected 0000", {dmem_bus.req, stall_out, misalign_err, pcsrc_out});
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_load_latency();
      int stall_cycles = 0;
      int req_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_instr(1'b1, 64'h0, 1'b0, 64'h40, 64'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
         dmem_bus.ready = (i == 3);
         dmem_bus.rdata = (i == 3) ? 64'hDEADBEEF_00000001 : 64'h0BAD_0BAD_0BAD_0BAD;
         #1;
         if (stall_out) stall_cycles++;
         if (dmem_bus.req) begin
            req_cycles++;
            n_cmp++;
            if ({dmem_bus.we, dmem_bus.addr} !== {1'b0, 64'h40}) begin
               n_err++; $display("FAIL load_req_fields: got we=%b addr=%h expected we=0 addr=40", dmem_bus.we, dmem_bus.addr);
            end
         end
         if (i < 3) begin
            n_cmp++;
            if (wb_valid !== 1'b0) begin
               n_err++; $display("FAIL load_bubble: got wb_valid=%b expected 0 (cycle %0d)", wb_valid, i);
            end
         end
      end
      @(negedge clk);
      clear_inputs();
      n_cmp++;
      if (stall_cycles != 3) begin
         n_err++; $display("FAIL load_stall_cycles: got %0d expected 3", stall_cycles);
      end
      n_cmp++;
      if (req_cycles != 3) begin
         n_err++; $display("FAIL load_req_cycles: got %0d expected 3", req_cycles);
      end
      n_cmp++;
      if ({wb_valid, wb_read_data, wb_write_reg, wb_regwrite, wb_memtoreg} !== {1'b1, 64'hDEADBEEF_00000001, 5'd5, 1'b1, 1'b1}) begin
         n_err++; $display("FAIL load_wb: got v=%b rd=%h wr=%0d rw=%b mtr=%b expected v=1 rd=deadbeef00000001 wr=5 rw=1 mtr=1",
                           wb_valid, wb_read_data, wb_write_reg, wb_regwrite, wb_memtoreg);
      end
   endtask

   task automatic test_store_zero_latency();
      int stall_cycles = 0;
      int we_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 2) begin
            clear_inputs();
            n_cmp++;
            if ({wb_valid, wb_regwrite, wb_read_data} !== {1'b1, 1'b0, 64'h0}) begin
               n_err++; $display("FAIL store_wb: got v=%b rw=%b rd=%h expected v=1 rw=0 rd=0", wb_valid, wb_regwrite, wb_read_data);
            end
         end else begin
            set_instr(1'b1, 64'h0, 1'b0, 64'h80, 64'h1234, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         end
         dmem_bus.ready = 1'b1;
         #1;
         if (stall_out) stall_cycles++;
         if (dmem_bus.req && dmem_bus.we) begin
            we_cycles++;
            n_cmp++;
            if ({dmem_bus.addr, dmem_bus.wdata} !== {64'h80, 64'h1234}) begin
               n_err++; $display("FAIL store_req_fields: got addr=%h wdata=%h expected 80/1234", dmem_bus.addr, dmem_bus.wdata);
            end
         end
      end
      dmem_bus.ready = 1'b0;
      n_cmp++;
      if (we_cycles != 1) begin
         n_err++; $display("FAIL store_we_cycles: got %0d expected 1", we_cycles);
      end
      n_cmp++;
      if (stall_cycles != 1) begin
         n_err++; $display("FAIL store_stall_cycles: got %0d expected 1", stall_cycles);
      end
   endtask

   task automatic test_alu_op();
      @(negedge clk);
      set_instr(1'b1, 64'h0, 1'b0, 64'h7, 64'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if ({stall_out, dmem_bus.req} !== 2'b00) begin
         n_err++; $display("FAIL alu_no_stall: got stall=%b req=%b expected 0 0", stall_out, dmem_bus.req);
      end
      @(negedge clk);
      clear_inputs();
      n_cmp++;
      if ({wb_valid, wb_alu_result, wb_write_reg, wb_regwrite, wb_read_data} !== {1'b1, 64'h7, 5'd3, 1'b1, 64'h0}) begin
         n_err++; $display("FAIL alu_wb: got v=%b alu=%h wr=%0d rw=%b rd=%h expected v=1 alu=7 wr=3 rw=1 rd=0",
                           wb_valid, wb_alu_result, wb_write_reg, wb_regwrite, wb_read_data);
      end
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      set_instr(1'b1, 64'h0, 1'b0, 64'h43, 64'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      n_cmp++;
      if ({misalign_err, stall_out, dmem_bus.req} !== 3'b100) begin
         n_err++; $display("FAIL misalign_cycle: got err/stall/req=%b expected 100", {misalign_err, stall_out, dmem_bus.req});
      end
      @(negedge clk);
      clear_inputs();
      #1;
      n_cmp++;
      if ({misalign_err, dmem_bus.req, wb_valid, wb_regwrite} !== 4'b0010) begin
         n_err++; $display("FAIL misalign_after: got err/req/wbv/rw=%b expected 0010", {misalign_err, dmem_bus.req, wb_valid, wb_regwrite});
      end
   endtask

   task automatic test_branch();
      @(negedge clk);
      set_instr(1'b1, 64'h200, 1'b1, 64'h0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if ({pcsrc_out, branch_target_out} !== {1'b1, 64'h200}) begin
         n_err++; $display("FAIL branch_taken: got pcsrc=%b target=%h expected 1/200", pcsrc_out, branch_target_out);
      end
      zero_in = 1'b0;
      #1;
      n_cmp++;
      if (pcsrc_out !== 1'b0) begin
         n_err++; $display("FAIL branch_not_taken: got pcsrc=%b expected 0", pcsrc_out);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      set_instr(1'b1, 64'h0, 1'b0, 64'h100, 64'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      dmem_bus.ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (dmem_bus.req !== 1'b1) begin
         n_err++; $display("FAIL rstwait_req_before: got %b expected 1", dmem_bus.req);
      end
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if ({dmem_bus.req, wb_valid} !== 2'b00) begin
         n_err++; $display("FAIL rstwait_immediate: got req/wbv=%b expected 00", {dmem_bus.req, wb_valid});
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      dmem_bus.ready = 1'b1;
      dmem_bus.rdata = 64'hFFFF_0000_FFFF_0000;
      #1;
      n_cmp++;
      if ({dmem_bus.req, stall_out} !== 2'b00) begin
         n_err++; $display("FAIL rstwait_idle: got req/stall=%b expected 00", {dmem_bus.req, stall_out});
      end
      @(negedge clk);
      dmem_bus.ready = 1'b0;
      n_cmp++;
      if ({wb_valid, wb_regwrite, dmem_bus.req} !== 3'b000) begin
         n_err++; $display("FAIL rstwait_no_stale_wb: got wbv/rw/req=%b expected 000", {wb_valid, wb_regwrite, dmem_bus.req});
      end
   endtask

   task automatic test_random();
      logic            busy = 1'b0;
      logic            have = 1'b0;
      logic            h_we = 1'b0;
      logic [XLEN-1:0] h_addr = 64'h0;
      logic [XLEN-1:0] h_wdata = 64'h0;
      exp_wb_t         held = '0;
      exp_wb_t         expw = '0;
      int              consumed = 0;
      int              cycles = 0;
      int              lat = 0;
      int              rsp_cnt = 0;
      logic            c_mem, c_misal, exp_stall;
      logic [XLEN-1:0] a64;
      int              r;
      @(negedge clk);
      clear_inputs();
      while (consumed < 300 && cycles < 4000) begin
         @(negedge clk);
         cycles++;
         n_cmp++;
         if (wb_valid !== expw.valid) begin
            n_err++; $display("FAIL rnd_wb_valid: got %b expected %b (cycle %0d)", wb_valid, expw.valid, cycles);
         end else if (expw.valid) begin
            n_cmp++;
            if ({wb_read_data, wb_alu_result, wb_write_reg, wb_memtoreg, wb_regwrite} !== {expw.rd, expw.alu, expw.wreg, expw.mtr, expw.rw}) begin
               n_err++; $display("FAIL rnd_wb_fields: got rd=%h alu=%h wr=%0d mtr=%b rw=%b expected rd=%h alu=%h wr=%0d mtr=%b rw=%b",
                                 wb_read_data, wb_alu_result, wb_write_reg, wb_memtoreg, wb_regwrite,
                                 expw.rd, expw.alu, expw.wreg, expw.mtr, expw.rw);
            end
         end else begin
            n_cmp++;
            if (wb_regwrite !== 1'b0) begin
               n_err++; $display("FAIL rnd_bubble_rw: got %b expected 0", wb_regwrite);
            end
         end
         if (!have) begin
            r = $urandom_range(0, 9);
            if (r < 7) a64 = {57'd0, 4'($urandom_range(0, 15)), 3'b000};
            else if (r == 7) a64 = {$urandom, $urandom} & ~64'h7;
            else a64 = {57'd0, 4'($urandom_range(0, 15)), 3'($urandom_range(1, 7))};
            r = $urandom_range(0, 5);
            set_instr($urandom_range(0, 9) != 0, {$urandom, $urandom}, 1'($urandom),
                      a64, {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 2) == 0,
                      (r == 2) || (r == 3), (r == 0) || (r == 1) || (r == 3),
                      1'($urandom), 1'($urandom));
            have = 1'b1;
         end
         if (dmem_bus.req) begin
            dmem_bus.ready = (rsp_cnt >= lat);
            if (dmem_bus.ready && !dmem_bus.we)
               dmem_bus.rdata = resp_mem.exists(dmem_bus.addr) ? resp_mem[dmem_bus.addr] : init_val(dmem_bus.addr);
            else
               dmem_bus.rdata = {$urandom, $urandom};
         end else begin
            dmem_bus.ready = 1'($urandom);
            dmem_bus.rdata = {$urandom, $urandom};
         end
         #1;
         c_mem   = in_valid & (memread_in | memwrite_in);
         c_misal = (alu_result_in[2:0] != 3'b000);
         exp_stall = busy ? ~dmem_bus.ready : (c_mem & ~c_misal);
         n_cmp++;
         if ({stall_out, pcsrc_out, misalign_err, dmem_bus.req} !==
             {exp_stall, ~busy & in_valid & branch_in & zero_in, ~busy & c_mem & c_misal, busy}) begin
            n_err++; $display("FAIL rnd_comb: got stall/pcsrc/merr/req=%b expected %b", {stall_out, pcsrc_out, misalign_err, dmem_bus.req},
                              {exp_stall, ~busy & in_valid & branch_in & zero_in, ~busy & c_mem & c_misal, busy});
         end
         n_cmp++;
         if (branch_target_out !== pc_in) begin
            n_err++; $display("FAIL rnd_target: got %h expected %h", branch_target_out, pc_in);
         end
         if (busy) begin
            n_cmp++;
            if ({dmem_bus.we, dmem_bus.addr, dmem_bus.wdata} !== {h_we, h_addr, h_wdata}) begin
               n_err++; $display("FAIL rnd_req_fields: got we=%b addr=%h wd=%h expected we=%b addr=%h wd=%h",
                                 dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, h_we, h_addr, h_wdata);
            end
         end
         if (dmem_bus.req) begin
            if (dmem_bus.ready) begin
               rsp_cnt = 0;
               if (dmem_bus.we) resp_mem[dmem_bus.addr] = dmem_bus.wdata;
            end else begin
               rsp_cnt++;
            end
         end
         expw = '0;
         if (busy) begin
            if (dmem_bus.ready) begin
               expw = held; busy = 1'b0; have = 1'b0; consumed++;
            end
         end else if (!in_valid) begin
            have = 1'b0; consumed++;
         end else if (c_mem && !c_misal) begin
            busy = 1'b1; lat = $urandom_range(0, 3); rsp_cnt = 0;
            h_we = memwrite_in; h_addr = alu_result_in; h_wdata = store_data_in;
            held.valid = 1'b1;
            held.rd    = memwrite_in ? 64'h0 : (model_mem.exists(alu_result_in) ? model_mem[alu_result_in] : init_val(alu_result_in));
            held.alu   = alu_result_in; held.wreg = write_reg_in; held.mtr = memtoreg_in;
            held.rw    = regwrite_in & ~memwrite_in;
            if (memwrite_in) model_mem[alu_result_in] = store_data_in;
         end else begin
            expw = '{valid: 1'b1, rd: 64'h0, alu: alu_result_in, wreg: write_reg_in,
                     mtr: memtoreg_in, rw: regwrite_in & ~c_mem};
            have = 1'b0; consumed++;
         end
      end
      n_cmp++;
      if (consumed < 300) begin
         n_err++; $display("FAIL rnd_timeout: got %0d retired expected 300 within 4000 cycles", consumed);
      end
      @(negedge clk);
      clear_inputs();
      n_cmp++;
      if (wb_valid !== expw.valid) begin
         n_err++; $display("FAIL rnd_final_wb: got %b expected %b", wb_valid, expw.valid);
      end
   endtask

   initial begin
      test_reset();
      test_load_latency();
      test_store_zero_latency();
      test_alu_op();
      test_misaligned();
      test_branch();
      test_reset_mid_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
